contador_idx: RTL and testbench
===============================

# contador_idx

Histogram stage placed directly downstream of the 3-cycle index delay line: consumes the delayed 4-bit index (`idx_dd`) plus a qualifying valid strobe, and keeps one occurrence counter per index value. A four-phase request/acknowledge port lets the test/control side read any counter without stalling the counting path. A sticky overflow flag reports counter wrap or saturation.

## Interface
Parameters:
- `IDX_W`, 4, index width; number of counters = 2^IDX_W
- `CNT_W`, 8, width of each counter and of `cnt_out`

Ports:
- `clk`  input  1  single clock, all logic on posedge
- `reset`  input  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- `idx_valid`  input  1  qualifies `idx` this cycle
- `idx`  input  IDX_W  delayed index from upstream stage
- `req`  input  1  read request, four-phase
- `req_idx`  input  IDX_W  counter to read, sampled when request accepted
- `ack`  output  1  read data valid, held until `req` low
- `cnt_out`  output  CNT_W  value of requested counter
- `ovf`  output  1  sticky: an increment hit a counter already at max
- `busy`  output  1  handshake in progress (state != IDLE)

## Operation
- Reset: all counters 0, `ack`=0, `cnt_out`=0, `ovf`=0, `busy`=0, FSM in IDLE.
- Counting: each posedge with `idx_valid`=1, counter[`idx`] increments by 1; `idx_valid`=0 leaves all counters unchanged. Counting never stalls, independent of FSM state.
- Increment at max (2^CNT_W−1): behaviour per Configuration; `ovf` set to 1 in both builds, cleared only by reset.
- FSM states: IDLE, READ, ACK.
  - IDLE: `req`=1 at posedge -> latch `req_idx`, go READ.
  - READ: unconditional -> ACK; `cnt_out` <= counter[latched idx] (value before any same-edge increment), `ack` <= 1.
  - ACK: `ack` held 1, `cnt_out` held; `req`=0 at posedge -> `ack` <= 0, go IDLE. `req`=1 stays ACK.
- `req_idx` changes after acceptance are ignored. `req` high in IDLE on the same edge `ack` falls is not possible (ACK->IDLE requires `req`=0); a new request is accepted the first edge `req` is 1 in IDLE.
- `cnt_out` retains last read value after `ack` drops until next READ.
- Unused FSM encodings recover to IDLE with `ack`=0.

## Timing
- Count latency: `idx_valid` at edge n -> updated counter readable by a READ at edge n+1 or later.
- Read latency: `req` sampled 1 at edge k -> READ; edge k+1 -> `ack`=1, `cnt_out` valid; minimum handshake 3 edges (k, k+1, drop at edge where `req`=0).
- Same-index collision: increment at READ edge is not reflected in that `cnt_out`; it is visible to the next read.
- Reset asserted mid-handshake or mid-count: immediate (asynchronous) return to reset values; `ack` falls without waiting for `req`.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `CONTADOR_IDX_SAT_EN` defined: counters saturate at 2^CNT_W−1; further increments leave value at max, `ovf`=1.
- Undefined: counters wrap max -> 0; `ovf`=1 on the wrap.

## Structure
- Package `contador_idx_pkg`: FSM state typedef (IDLE, READ, ACK), default `IDX_W`/`CNT_W` constants, max-count constant derived from `CNT_W`.
- Sub-module `banco_contadores`: 2^IDX_W counter array with increment port, read mux and overflow detect; top holds FSM and output registers.

## Test plan
- Reset then 5 cycles `idx_valid`=1, `idx`=3; read `req_idx`=3 -> `ack` 2 edges after `req`, `cnt_out`=5; other indices read 0.
- Handshake hold: keep `req`=1 for 10 cycles -> `ack`=1 and `cnt_out` stable throughout; drop `req` -> `ack`=0 next edge, `busy`=0.
- Collision: `idx_valid`=1, `idx`=7 every cycle while reading index 7 -> `cnt_out` equals count before READ edge; next read shows +N.
- Overflow (CNT_W=8): 256 increments on `idx`=0 -> without macro counter 0, `ovf`=1; with `CONTADOR_IDX_SAT_EN` counter 255, `ovf`=1; 300 increments with macro -> still 255.
- Reset mid-handshake: assert `reset` while `ack`=1 -> `ack`, `cnt_out`, `ovf`, `busy` 0 immediately, counters 0.
- Invalid gating: `idx`=9 toggling with `idx_valid`=0 for 20 cycles -> counter[9] stays 0.

Source files
------------

// File: rtl/contador_idx_pkg.sv
// Shared types and constants for the contador_idx histogram stage.
package contador_idx_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        ACK  = 2'b10
    } state_t;

    // Largest value a w-bit counter can hold (w < 32).
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/banco_contadores.sv
// 2^IDX_W occurrence counters with one increment port, one read port and a sticky overflow flag.
// CONTADOR_IDX_SAT_EN selects saturating counters; otherwise counters wrap.
module banco_contadores
    import contador_idx_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data,
    output logic             ovf
);

    localparam int             N   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [N-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc_en) begin
            if (cnt[inc_idx] == MAX) begin
                ovf <= 1'b1;
`ifdef CONTADOR_IDX_SAT_EN
                cnt[inc_idx] <= MAX;
`else
                cnt[inc_idx] <= '0;
`endif
            end else begin
                cnt[inc_idx] <= cnt[inc_idx] + 1'b1;
            end
        end
    end

    // Pre-increment value: a same-edge increment is not seen by the reader.
    assign rd_data = cnt[rd_idx];

endmodule

// File: rtl/contador_idx.sv
// Histogram stage: per-index counters plus a four-phase read port that never stalls counting.
// Build option CONTADOR_IDX_SAT_EN makes the counters saturate instead of wrap.
module contador_idx
    import contador_idx_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idx_valid,
    input  logic [IDX_W-1:0] idx,
    input  logic             req,
    input  logic [IDX_W-1:0] req_idx,
    output logic             ack,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf,
    output logic             busy
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   rd_idx, rd_idx_n;
    logic               ack_n;
    logic [CNT_W-1:0]   cnt_n, rd_data;

    banco_contadores #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_banco (
        .clk     (clk),
        .reset   (reset),
        .inc_en  (idx_valid),
        .inc_idx (idx),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .ovf     (ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_idx  <= '0;
            ack     <= 1'b0;
            cnt_out <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            rd_idx  <= rd_idx_n;
            ack     <= ack_n;
            cnt_out <= cnt_n;
            busy    <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        rd_idx_n = rd_idx;
        ack_n    = ack;
        cnt_n    = cnt_out;
        case (state)
            IDLE: begin
                if (req) begin
                    rd_idx_n = req_idx;
                    state_n  = READ;
                end
            end
            READ: begin
                state_n = ACK;
                ack_n   = 1'b1;
                cnt_n   = rd_data;
            end
            ACK: begin
                if (!req) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                ack_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_contador_idx.sv
// Directed scoreboard bench for contador_idx; reference counters live in the bench.
module tb_contador_idx;
    import contador_idx_pkg::*;

    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             idx_valid = 1'b0;
    logic [IDX_W-1:0] idx = '0;
    logic             req = 1'b0;
    logic [IDX_W-1:0] req_idx = '0;
    logic             ack;
    logic [CNT_W-1:0] cnt_out;
    logic             ovf;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int model [16];
    int model_ovf = 0;
    int sb [$];

    contador_idx #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .idx_valid (idx_valid),
        .idx       (idx),
        .req       (req),
        .req_idx   (req_idx),
        .ack       (ack),
        .cnt_out   (cnt_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 0;
        model_ovf = 0;
    endtask

    // One clock: drive at negedge, advance model on posedge, leave time at posedge+1.
    task automatic tick(input logic v, input int vi, input logic r, input int ri);
        @(negedge clk);
        idx_valid = v;
        idx       = IDX_W'(vi);
        req       = r;
        req_idx   = IDX_W'(ri);
        @(posedge clk);
        if (v) begin
            if (model[vi] == CNT_MAX) begin
                model_ovf = 1;
`ifdef CONTADOR_IDX_SAT_EN
                model[vi] = CNT_MAX;
`else
                model[vi] = 0;
`endif
            end else begin
                model[vi] = model[vi] + 1;
            end
        end
        #1;
    endtask

    // Full handshake on counter ri, optionally counting vi each cycle throughout.
    task automatic rd(input int ri, input int hold, input logic v, input int vi);
        int exp;
        tick(v, vi, 1'b1, ri);
        chk("ack_in_read", int'(ack), 0);
        chk("busy_in_read", int'(busy), 1);
        sb.push_back(model[ri]);
        tick(v, vi, 1'b1, ri ^ 5);
        chk("ack_rise", int'(ack), 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            exp = -1;
        end else begin
            exp = sb.pop_front();
        end
        chk($sformatf("cnt_out[%0d]", ri), int'(cnt_out), exp);
        chk("ovf", int'(ovf), model_ovf);
        for (int h = 0; h < hold; h++) begin
            tick(v, vi, 1'b1, (ri + h + 1) % 16);
            chk("ack_hold", int'(ack), 1);
            chk("cnt_hold", int'(cnt_out), exp);
        end
        tick(v, vi, 1'b0, 0);
        chk("ack_fall", int'(ack), 0);
        chk("busy_idle", int'(busy), 0);
        chk("cnt_retain", int'(cnt_out), exp);
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        #12;
        chk("rst_ack", int'(ack), 0);
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // basic count and reads
        for (int i = 0; i < 5; i++) tick(1'b1, 3, 1'b0, 0);
        rd(3, 0, 1'b0, 0);
        rd(5, 0, 1'b0, 0);
        rd(0, 0, 1'b0, 0);

        // long hold with changing req_idx
        rd(3, 10, 1'b0, 0);

        // idx_valid=0 gating
        for (int i = 0; i < 20; i++) tick(1'b0, (i % 2) ? 9 : 6, 1'b0, 0);
        rd(9, 0, 1'b0, 0);

        // collision: counting index 7 while reading it
        for (int i = 0; i < 3; i++) tick(1'b1, 7, 1'b0, 0);
        rd(7, 2, 1'b1, 7);
        rd(7, 0, 1'b0, 0);

        // overflow on counter 0
        for (int i = 0; i < 256; i++) tick(1'b1, 0, 1'b0, 0);
        chk("ovf_after_256", int'(ovf), 1);
        rd(0, 0, 1'b0, 0);
        for (int i = 0; i < 44; i++) tick(1'b1, 0, 1'b0, 0);
        rd(0, 0, 1'b0, 0);
        chk("ovf_sticky", int'(ovf), 1);

        // asynchronous reset while ack is high
        tick(1'b0, 0, 1'b1, 3);
        tick(1'b0, 0, 1'b1, 3);
        chk("pre_rst_ack", int'(ack), 1);
        chk("pre_rst_cnt", int'(cnt_out), model[3]);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ack", int'(ack), 0);
        chk("async_cnt", int'(cnt_out), 0);
        chk("async_ovf", int'(ovf), 0);
        chk("async_busy", int'(busy), 0);
        model_clear();
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rd(3, 0, 1'b0, 0);
        rd(0, 0, 1'b0, 0);
        rd(7, 0, 1'b0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
